// File: rtl/tx_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tx_ctrl_pkg
// Purpose : Shared state encoding and constants for the I2C TX controller.
// Rev     : 1.0  initial release
// ============================================================================
package tx_ctrl_pkg;

  // Controller states, explicitly 3 bits wide.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    AACK  = 3'd3,
    DATA  = 3'd4,
    DACK  = 3'd5,
    STOP  = 3'd6
  } tx_state_t;

  // Bit index of the last bit in a byte (TXCount value on the 8th bit).
  localparam logic [5:0] BYTE_LAST = 6'd7;

  // Default number of data bytes per write transaction.
  localparam int BURST_LEN_DEFAULT = 4;

endpackage : tx_ctrl_pkg
`default_nettype wire

// File: rtl/tx_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : tx_controller_if
// Purpose : Strobe/status bundle between the TX controller and its datapath
//           (two 8-bit TX shift buffers, TXCount and BurstCnt counters).
//           master = controller side, slave = datapath side.
// Rev     : 1.0  initial release
// ============================================================================
interface tx_controller_if;

  // Requests and status into the controller
  logic       StartTX;
  logic       Ackrecvd;
  logic [5:0] TXCount;
  logic [5:0] BurstCnt;

  // Counter strobes
  logic       ResetTXCount;
  logic       IncTXCount;
  logic       ResetBurstCnt;
  logic       IncBurstCnt;

  // Buffer strobes
  logic       LoadTXBuf0;
  logic       LoadTXBuf1;
  logic       ShiftTXBuf0;
  logic       ShiftTXBuf1;
  logic       PassTXBuf;
  logic       LoadAddr;

  // Bus condition controls
  logic       SendStartSig;
  logic       SendWriteSig;
  logic       SendStopSig;
  logic       WaitAck;
  logic       SDA;
  logic       SCL;

  modport master (
    input  StartTX, Ackrecvd, TXCount, BurstCnt,
    output ResetTXCount, IncTXCount, ResetBurstCnt, IncBurstCnt,
           LoadTXBuf0, LoadTXBuf1, ShiftTXBuf0, ShiftTXBuf1, PassTXBuf,
           LoadAddr, SendStartSig, SendWriteSig, SendStopSig, WaitAck,
           SDA, SCL
  );

  modport slave (
    output StartTX, Ackrecvd, TXCount, BurstCnt,
    input  ResetTXCount, IncTXCount, ResetBurstCnt, IncBurstCnt,
           LoadTXBuf0, LoadTXBuf1, ShiftTXBuf0, ShiftTXBuf1, PassTXBuf,
           LoadAddr, SendStartSig, SendWriteSig, SendStopSig, WaitAck,
           SDA, SCL
  );

endinterface : tx_controller_if
`default_nettype wire

// File: rtl/tx_controller.sv
`default_nettype none
// ============================================================================
// Module  : tx_controller
// Purpose : Control FSM for a double-buffered I2C master write path.
//           Sequences START, address+W, BURST_LEN data bytes with ACK waits,
//           and STOP, one bit per clk. Data buffers ping-pong: while the
//           buffer selected by sel shifts, the other one is reloaded.
// Options : `define TXCTRL_ACK_TIMEOUT_EN to abort (STOP) after ACK_TIMEOUT
//           cycles without an ACK; otherwise ACK states wait indefinitely.
// Rev     : 1.0  initial release
// ============================================================================
module tx_controller
  import tx_ctrl_pkg::*;
#(
  parameter int BURST_LEN   = BURST_LEN_DEFAULT,
  parameter int ACK_TIMEOUT = 15
) (
  input  wire              clk,
  input  wire              reset,
  tx_controller_if.master  bus
);

  // Elaboration-time parameter range checks
  if (BURST_LEN < 1 || BURST_LEN > 63) begin : g_chk_burst_len
    $error("tx_controller: BURST_LEN must be in 1..63");
  end
  if (ACK_TIMEOUT < 1) begin : g_chk_ack_timeout
    $error("tx_controller: ACK_TIMEOUT must be at least 1");
  end

  localparam logic [5:0] c_BURST_LEN6 = 6'(BURST_LEN);
  localparam logic [6:0] c_BURST_LEN7 = 7'(BURST_LEN);

  tx_state_t r_state;
  logic      r_sel;        // active data buffer: 0 = buffer0, 1 = buffer1

  logic       w_bit_first;
  logic       w_bit_last;
  logic [6:0] w_burst_p1;  // BurstCnt + 1 without wrap
  logic       w_timeout;

  assign w_bit_first = (bus.TXCount == 6'd0);
  assign w_bit_last  = (bus.TXCount == BYTE_LAST);
  assign w_burst_p1  = {1'b0, bus.BurstCnt} + 7'd1;

`ifdef TXCTRL_ACK_TIMEOUT_EN
  localparam int c_WAIT_W = ($clog2(ACK_TIMEOUT + 1) < 4) ? 4 : $clog2(ACK_TIMEOUT + 1);

  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_nxt;
  logic                w_in_ack;

  assign w_in_ack   = (r_state == AACK) || (r_state == DACK);
  assign w_wait_nxt = r_wait_cnt + 1'b1;
  // Abort on the edge where the count of un-ACKed cycles reaches the limit
  assign w_timeout  = w_in_ack && !bus.Ackrecvd &&
                      (w_wait_nxt == c_WAIT_W'(ACK_TIMEOUT));

  // Wait counter: zero outside ACK states so every ACK window starts from 0
  always_ff @(posedge clk) begin
    if (reset || !w_in_ack || bus.Ackrecvd) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State and buffer-select sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.StartTX) r_state <= START;
        end
        START: begin
          r_state <= ADDR;
        end
        ADDR: begin
          if (w_bit_last) begin
            r_sel   <= 1'b1;       // first data byte was preloaded into buffer1
            r_state <= AACK;
          end
        end
        AACK: begin
          if (bus.Ackrecvd)   r_state <= DATA;
          else if (w_timeout) r_state <= STOP;
        end
        DATA: begin
          if (w_bit_last) r_state <= DACK;
        end
        DACK: begin
          if (bus.Ackrecvd) begin
            if (bus.BurstCnt == c_BURST_LEN6) begin
              r_state <= STOP;
            end else begin
              r_sel   <= ~r_sel;
              r_state <= DATA;
            end
          end else if (w_timeout) begin
            r_state <= STOP;
          end
        end
        STOP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Strobe decode from the registered state, sel and inputs
  always_comb begin
    bus.ResetTXCount  = 1'b0;
    bus.IncTXCount    = 1'b0;
    bus.ResetBurstCnt = 1'b0;
    bus.IncBurstCnt   = 1'b0;
    bus.LoadTXBuf0    = 1'b0;
    bus.LoadTXBuf1    = 1'b0;
    bus.ShiftTXBuf0   = 1'b0;
    bus.ShiftTXBuf1   = 1'b0;
    bus.PassTXBuf     = 1'b0;
    bus.LoadAddr      = 1'b0;
    bus.SendStartSig  = 1'b0;
    bus.SendWriteSig  = 1'b0;
    bus.SendStopSig   = 1'b0;
    bus.WaitAck       = 1'b0;
    bus.SDA           = 1'b1;
    bus.SCL           = 1'b0;
    case (r_state)
      IDLE: begin
        bus.ResetTXCount  = 1'b1;
        bus.ResetBurstCnt = 1'b1;
        bus.SCL           = 1'b1;
      end
      START: begin
        bus.SendStartSig = 1'b1;
        bus.LoadAddr     = 1'b1;
        bus.ResetTXCount = 1'b1;
        bus.SDA          = 1'b0;
        bus.SCL          = 1'b1;
      end
      ADDR: begin
        bus.ShiftTXBuf0  = 1'b1;
        bus.IncTXCount   = 1'b1;
        bus.LoadTXBuf1   = w_bit_first;
        bus.SendWriteSig = w_bit_last;
      end
      AACK, DACK: begin
        bus.WaitAck      = 1'b1;
        bus.ResetTXCount = 1'b1;
      end
      DATA: begin
        bus.ShiftTXBuf0 = ~r_sel;
        bus.ShiftTXBuf1 = r_sel;
        bus.PassTXBuf   = r_sel;
        bus.IncTXCount  = 1'b1;
        bus.IncBurstCnt = w_bit_last;
        // Reload the idle buffer only if another byte will follow this one
        if (w_bit_first && (w_burst_p1 < c_BURST_LEN7)) begin
          bus.LoadTXBuf0 = r_sel;
          bus.LoadTXBuf1 = ~r_sel;
        end
      end
      STOP: begin
        bus.SendStopSig = 1'b1;
        bus.SDA         = 1'b0;
        bus.SCL         = 1'b1;
      end
      default: begin
        bus.SDA = 1'b1;
      end
    endcase
  end

endmodule : tx_controller
`default_nettype wire

// File: tb/tb_tx_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_tx_controller
// Purpose : Scoreboard bench for tx_controller. The stimulus process pushes
//           the hand-derived strobe vector expected for each cycle; a monitor
//           pops and compares on the falling edge. External TXCount/BurstCnt
//           counters are modelled here.
// Options : honours TXCTRL_ACK_TIMEOUT_EN (NACK-abort scenario).
// Rev     : 1.0  initial release
// ============================================================================
module tb_tx_controller;

  localparam int BL = 4;

  // Strobe vector bit masks
  localparam logic [15:0] M_RTC  = 16'h8000;
  localparam logic [15:0] M_INC  = 16'h4000;
  localparam logic [15:0] M_RBC  = 16'h2000;
  localparam logic [15:0] M_IBC  = 16'h1000;
  localparam logic [15:0] M_LD0  = 16'h0800;
  localparam logic [15:0] M_LD1  = 16'h0400;
  localparam logic [15:0] M_SH0  = 16'h0200;
  localparam logic [15:0] M_SH1  = 16'h0100;
  localparam logic [15:0] M_PASS = 16'h0080;
  localparam logic [15:0] M_SST  = 16'h0040;
  localparam logic [15:0] M_SW   = 16'h0020;
  localparam logic [15:0] M_SSP  = 16'h0010;
  localparam logic [15:0] M_WA   = 16'h0008;
  localparam logic [15:0] M_LA   = 16'h0004;
  localparam logic [15:0] M_SDA  = 16'h0002;
  localparam logic [15:0] M_SCL  = 16'h0001;

  localparam logic [15:0] V_IDLE  = M_RTC | M_RBC | M_SDA | M_SCL;
  localparam logic [15:0] V_START = M_SST | M_LA | M_RTC | M_SCL;
  localparam logic [15:0] V_ADDR  = M_SH0 | M_INC | M_SDA;
  localparam logic [15:0] V_ACK   = M_WA | M_RTC | M_SDA;
  localparam logic [15:0] V_DATA0 = M_SH0 | M_INC | M_SDA;
  localparam logic [15:0] V_DATA1 = M_SH1 | M_PASS | M_INC | M_SDA;
  localparam logic [15:0] V_STOP  = M_SSP | M_SCL;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tx_controller_if bus ();

  tx_controller #(.BURST_LEN(BL), .ACK_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External counter models
  logic [5:0] m_tx = 6'd0;
  logic [5:0] m_burst = 6'd0;
  always @(posedge clk) begin
    if (bus.ResetTXCount === 1'b1)    m_tx <= 6'd0;
    else if (bus.IncTXCount === 1'b1) m_tx <= m_tx + 6'd1;
    if (bus.ResetBurstCnt === 1'b1)    m_burst <= 6'd0;
    else if (bus.IncBurstCnt === 1'b1) m_burst <= m_burst + 6'd1;
  end
  assign bus.TXCount  = m_tx;
  assign bus.BurstCnt = m_burst;

  logic [15:0] w_got;
  assign w_got = {bus.ResetTXCount, bus.IncTXCount, bus.ResetBurstCnt,
                  bus.IncBurstCnt, bus.LoadTXBuf0, bus.LoadTXBuf1,
                  bus.ShiftTXBuf0, bus.ShiftTXBuf1, bus.PassTXBuf,
                  bus.SendStartSig, bus.SendWriteSig, bus.SendStopSig,
                  bus.WaitAck, bus.LoadAddr, bus.SDA, bus.SCL};

  // Scoreboard queues (expected vector and check name)
  logic [15:0] q_v[$];
  string       q_n[$];
  int n_checks = 0;
  int n_errors = 0;

  // Monitor: compare one expected entry per cycle, away from the active edge
  always @(negedge clk) begin
    if (q_v.size() > 0) begin
      logic [15:0] ev;
      string       nm;
      ev = q_v.pop_front();
      nm = q_n.pop_front();
      n_checks++;
      if (w_got !== ev) begin
        n_errors++;
        $display("FAIL %s: got %04h expected %04h (t=%0t)", nm, w_got, ev, $time);
      end
    end
  end

  // Push expectation for the current cycle, then advance to next edge + 1
  task automatic step(input logic [15:0] v, input string nm);
    q_v.push_back(v);
    q_n.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_addr();
    for (int b = 0; b < 8; b++) begin
      logic [15:0] v;
      v = V_ADDR;
      if (b == 0) v = v | M_LD1;
      if (b == 7) v = v | M_SW;
      step(v, $sformatf("addr_bit%0d", b));
    end
  endtask

  // Data byte k (1-based); odd bytes come from buffer1, even from buffer0
  task automatic do_byte(input int k, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      logic [15:0] v;
      v = (k % 2 == 1) ? V_DATA1 : V_DATA0;
      if (b == 0 && k < BL) v = v | ((k % 2 == 1) ? M_LD0 : M_LD1);
      if (b == 7) v = v | M_IBC;
      step(v, $sformatf("data%0d_bit%0d", k, b));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.StartTX  = 1'b0;
    bus.Ackrecvd = 1'b0;
    @(posedge clk);
    #1;
    step(V_IDLE, "reset_c1");
    step(V_IDLE, "reset_c2");
    reset = 1'b0;
    step(V_IDLE, "idle");

    // Transaction 1: ACK delayed 5 cycles in AACK, full burst
    bus.StartTX = 1'b1;
    step(V_IDLE, "idle_start_req");
    bus.StartTX = 1'b0;
    step(V_START, "start");
    do_addr();
    for (int i = 0; i < 5; i++) step(V_ACK, $sformatf("aack_wait%0d", i));
    bus.Ackrecvd = 1'b1;
    step(V_ACK, "aack_accept");
    for (int k = 1; k <= BL; k++) begin
      do_byte(k, 8);
      step(V_ACK, $sformatf("dack%0d", k));
    end
    // StartTX high during STOP: level request restarts from IDLE
    bus.StartTX = 1'b1;
    step(V_STOP, "stop");
    step(V_IDLE, "idle_restart");

    // Transaction 2: StartTX held throughout, reset mid-DATA at TXCount 3
    step(V_START, "start2");
    do_addr();
    step(V_ACK, "aack2_accept");
    do_byte(1, 3);
    reset = 1'b1;
    step(V_DATA1, "data1_bit3_reset");
    reset = 1'b0;
    bus.StartTX  = 1'b0;
    bus.Ackrecvd = 1'b0;
    step(V_IDLE, "after_reset");
    step(V_IDLE, "after_reset2");

    // Transaction 3: no ACK at all
    bus.StartTX = 1'b1;
    step(V_IDLE, "idle_start_req3");
    bus.StartTX = 1'b0;
    step(V_START, "start3");
    do_addr();
`ifdef TXCTRL_ACK_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step(V_ACK, $sformatf("nack_wait%0d", i));
    step(V_STOP, "nack_stop");
    step(V_IDLE, "nack_idle");
`else
    for (int i = 0; i < 20; i++) step(V_ACK, $sformatf("nack_hold%0d", i));
    reset = 1'b1;
    step(V_ACK, "nack_hold_reset");
    reset = 1'b0;
    step(V_IDLE, "nack_idle");
`endif

    @(negedge clk);
    if (q_v.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q_v.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_tx_controller
`default_nettype wire

// File: doc/tx_controller.md
Name:
tx_controller

Overview:
- Control FSM for the transmit side of a double-buffered I2C master write path.
- Sequences START, the address+W byte, a burst of data bytes, ACK waits and STOP, with one bit per clk.
- Drives load/shift/select strobes to two external 8-bit TX shift buffers, and reset/increment strobes to two external 6-bit counters (bit count TXCount, byte count BurstCnt).
- Ping-pongs the buffers: while one buffer shifts, the other is reloaded.

Parameters:
- BURST_LEN, 4, data bytes per transaction (legal range 1..63).
- ACK_TIMEOUT, 15, cycles to wait for an ACK before abort (used only with the optional feature).

Ports:
- clk, in, 1, single clock; everything is on the rising edge.
- reset, in, 1, synchronous, active-high.
- StartTX, in, 1, level request to start a transaction.
- Ackrecvd, in, 1, slave ACK sampled during ACK states.
- TXCount, in, 6, external bit counter value.
- BurstCnt, in, 6, external byte counter value.
- ResetTXCount, out, 1, clear bit counter. IncTXCount, out, 1, increment bit counter.
- ResetBurstCnt, out, 1, clear byte counter. IncBurstCnt, out, 1, increment byte counter.
- LoadTXBuf0, out, 1, load buffer0. LoadTXBuf1, out, 1, load buffer1.
- ShiftTXBuf0, out, 1, shift buffer0. ShiftTXBuf1, out, 1, shift buffer1.
- PassTXBuf, out, 1, SDA data mux select (0 = buffer0, 1 = buffer1).
- SendStartSig, out, 1, START condition. SendWriteSig, out, 1, marks the R/W bit. SendStopSig, out, 1, STOP condition.
- WaitAck, out, 1, ACK window. LoadAddr, out, 1, load {addr[6:0],1'b0} into buffer0.
- SDA, out, 1, controller SDA level (1 = release).
- SCL, out, 1, 1 = SCL held high by controller; 0 = bit-clock generator owns SCL.

Behaviour:
- All outputs are combinational decode of the registered state, the sel bit and the inputs. Zero latency from state to strobe.
- External counters update on the edge following Inc/Reset.
- Internal registers: state, sel (active data buffer). On reset: state = IDLE, sel = 1.
- Any strobe not listed for a state is 0.
- IDLE: ResetTXCount = 1, ResetBurstCnt = 1, SDA = 1, SCL = 1.
  - StartTX = 1 -> START.
  - StartTX is level-sensitive; if it is still high after STOP, a new transaction starts.
- START (1 cycle): SendStartSig = 1, LoadAddr = 1, ResetTXCount = 1, SDA = 0, SCL = 1 -> ADDR.
- ADDR: ShiftTXBuf0 = 1, IncTXCount = 1, PassTXBuf = 0, SDA = 1, SCL = 0.
  - LoadTXBuf1 = 1 when TXCount == 0 (preloads the first data byte).
  - SendWriteSig = 1 when TXCount == 7.
  - TXCount == 7 -> AACK, with sel <= 1.
- AACK / DACK: WaitAck = 1, ResetTXCount = 1, SDA = 1, SCL = 0.
  - Ackrecvd is accepted in any cycle of the state, including the first.
  - AACK + Ackrecvd -> DATA.
  - DACK + Ackrecvd: BurstCnt == BURST_LEN -> STOP; otherwise sel <= ~sel and -> DATA.
  - Without Ackrecvd: remain in the state.
- DATA: shift the buffer selected by sel (ShiftTXBuf0 = ~sel, ShiftTXBuf1 = sel), PassTXBuf = sel, IncTXCount = 1, SDA = 1, SCL = 0.
  - Reload the other buffer (LoadTXBuf[~sel] = 1) when TXCount == 0 and BurstCnt + 1 < BURST_LEN.
  - TXCount == 7: IncBurstCnt = 1 -> DACK.
- STOP (1 cycle): SendStopSig = 1, SDA = 0, SCL = 1 -> IDLE.
- StartTX is ignored outside IDLE.
- Reset in any state -> IDLE on the next edge. No STOP is issued.
- Comparisons are 6-bit unsigned. BurstCnt + 1 is computed at 7 bits (no wrap).

Optional Feature:
TXCTRL_ACK_TIMEOUT_EN
- Defined: a 4+ bit wait counter clears on entry to AACK/DACK and increments each cycle without Ackrecvd. When it reaches ACK_TIMEOUT -> STOP (NACK abort).
- Undefined: the counter is absent and AACK/DACK wait indefinitely.

Decomposition:
- Shared package tx_ctrl_pkg holds:
  - state enum (IDLE, START, ADDR, AACK, DATA, DACK, STOP);
  - constants BYTE_LAST = 6'd7 and default BURST_LEN.
- No sub-module is needed; the optional timeout counter stays inline.

Test Plan:
- Reset held 2 cycles -> IDLE; ResetTXCount = ResetBurstCnt = 1, SDA = 1, SCL = 1, all other strobes 0.
- StartTX = 1 with a modelled TXCount counter:
  - START lasts 1 cycle with LoadAddr = 1 and SendStartSig = 1.
  - ADDR lasts 8 cycles; LoadTXBuf1 on its first cycle and SendWriteSig on its 8th.
- Ackrecvd held 1, BURST_LEN = 4, modelled counters:
  - PassTXBuf sequence across the 4 data bytes is 1, 0, 1, 0.
  - LoadTXBuf alternates 0, 1, 0; there is no load during byte 4.
  - IncBurstCnt pulses 4 times, then 1 STOP cycle, then IDLE.
- Ackrecvd = 0 for 5 cycles in AACK -> WaitAck stays 1 and the state is held. Raising Ackrecvd -> DATA next edge.
- Reset asserted mid-DATA (TXCount = 3) -> IDLE next edge; SendStopSig never pulses.
- With TXCTRL_ACK_TIMEOUT_EN and Ackrecvd = 0 -> STOP after ACK_TIMEOUT = 15 cycles in AACK, then IDLE.
